// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: the CPU request channel, the tag/data array
// access channel and the memory word channel.
//
//   slave  modport : the cache controller's view (it consumes CPU requests,
//                    array lookup results and memory responses, and drives
//                    completion, array commands and memory requests).
//   master modport : the environment's view (CPU, tag/data array, memory).
//
// Signal groups:
//   cpu_*  : request/completion handshake with the CPU (cpu_req held until
//            cpu_ready; cpu_ready is a one-cycle pulse with cpu_rdata).
//   arr_*  : array results (hit, hit way, LRU victim info, combinational read
//            word) and array commands (set/way/offset select, word write,
//            tag write with dirty value, LRU touch).
//   mem_*  : one word per mem_ack, writeback (mem_we=1) or refill (mem_we=0).
//   busy   : controller is not idle.
interface cache_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 18,
  parameter int SET_WIDTH     = 8,
  parameter int OFFSET_WIDTH  = 6,
  parameter int WAY           = 4
);
  localparam int WW = (WAY > 1) ? $clog2(WAY) : 1;

  // CPU side
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic                     cpu_ready;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     busy;

  // Tag/data array side
  logic                     arr_hit;
  logic [WW-1:0]            arr_hit_way;
  logic [WW-1:0]            arr_victim_way;
  logic                     arr_victim_dirty;
  logic [TAG_WIDTH-1:0]     arr_victim_tag;
  logic [DATA_WIDTH-1:0]    arr_rdata;
  logic [SET_WIDTH-1:0]     arr_set;
  logic [WW-1:0]            arr_way;
  logic [OFFSET_WIDTH-1:0]  arr_offset;
  logic [DATA_WIDTH-1:0]    arr_wdata;
  logic                     arr_data_we;
  logic                     arr_tag_we;
  logic                     arr_dirty_val;
  logic                     arr_lru_touch;

  // Memory side
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ack;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  arr_hit, arr_hit_way, arr_victim_way, arr_victim_dirty,
    input  arr_victim_tag, arr_rdata,
    input  mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, busy,
    output arr_set, arr_way, arr_offset, arr_wdata, arr_data_we,
    output arr_tag_we, arr_dirty_val, arr_lru_touch,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output arr_hit, arr_hit_way, arr_victim_way, arr_victim_dirty,
    output arr_victim_tag, arr_rdata,
    output mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, busy,
    input  arr_set, arr_way, arr_offset, arr_wdata, arr_data_we,
    input  arr_tag_we, arr_dirty_val, arr_lru_touch,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: control FSM for a set-associative write-back, write-allocate
// cache with an external tag/data/LRU array and a word-serial memory port.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset; forces IDLE and zeroes every
//              output and internal latch immediately (an in-flight burst is
//              abandoned with no further array writes)
//   bus      : cache_ctrl_if.slave (CPU, array and memory channels)
//
// Flow: IDLE accepts a request and latches it; LOOKUP either completes a hit
// or records the LRU victim; WRITEBACK streams a dirty victim block to memory
// word by word; REFILL streams the new block in word by word and then returns
// to LOOKUP so that the retry completes as an ordinary hit.
module cache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 18,
  parameter int SET_WIDTH     = 8,
  parameter int OFFSET_WIDTH  = 6,
  parameter int WAY           = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  cache_ctrl_if.slave  bus
);
  localparam int WW = (WAY > 1) ? $clog2(WAY) : 1;
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  state_t                  state;
  logic                    req_we;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [SET_WIDTH-1:0]    req_set;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [WW-1:0]           victim_way;
  logic [TAG_WIDTH-1:0]    victim_tag;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   rdata;

  logic last_word;
  assign last_word = (cnt == LAST_WORD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_we     <= 1'b0;
      req_tag    <= '0;
      req_set    <= '0;
      req_offset <= '0;
      req_wdata  <= '0;
      victim_way <= '0;
      victim_tag <= '0;
      cnt        <= '0;
      ready      <= 1'b0;
      rdata      <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          // A request still asserted while cpu_ready is showing belongs to
          // the transaction just completed, so it must not start a new one.
          if (bus.cpu_req && !ready) begin
            req_we     <= bus.cpu_we;
            req_tag    <= bus.cpu_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
            req_set    <= bus.cpu_addr[OFFSET_WIDTH +: SET_WIDTH];
            req_offset <= bus.cpu_addr[OFFSET_WIDTH-1:0];
            req_wdata  <= bus.cpu_wdata;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus.arr_hit) begin
            if (!req_we) rdata <= bus.arr_rdata;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            victim_way <= bus.arr_victim_way;
            victim_tag <= bus.arr_victim_tag;
            cnt        <= '0;
            state      <= bus.arr_victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          // cnt wraps to zero on the final word, ready for the refill burst.
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready = ready;
  assign bus.cpu_rdata = rdata;
  assign bus.busy      = (state != IDLE);

  // Array and memory commands are decoded from the state so that array
  // writes land in the same cycle as the hit or mem_ack that causes them,
  // and memory requests hold steady until acknowledged (they depend only
  // on state and cnt, which change only on mem_ack).
  always_comb begin
    bus.arr_set       = req_set;
    bus.arr_way       = '0;
    bus.arr_offset    = '0;
    bus.arr_wdata     = '0;
    bus.arr_data_we   = 1'b0;
    bus.arr_tag_we    = 1'b0;
    bus.arr_dirty_val = 1'b0;
    bus.arr_lru_touch = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    case (state)
      IDLE: ;
      LOOKUP: begin
        bus.arr_way    = bus.arr_hit_way;
        bus.arr_offset = req_offset;
        if (bus.arr_hit) begin
          bus.arr_lru_touch = 1'b1;
          if (req_we) begin
            bus.arr_data_we   = 1'b1;
            bus.arr_wdata     = req_wdata;
            bus.arr_tag_we    = 1'b1;
            bus.arr_dirty_val = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = {victim_tag, req_set, cnt};
        bus.arr_way    = victim_way;
        bus.arr_offset = cnt;
        bus.mem_wdata  = bus.arr_rdata;
      end
      REFILL: begin
        bus.mem_req    = 1'b1;
        bus.mem_addr   = {req_tag, req_set, cnt};
        bus.arr_way    = victim_way;
        bus.arr_offset = cnt;
        if (bus.mem_ack) begin
          bus.arr_data_we = 1'b1;
          bus.arr_wdata   = bus.mem_rdata;
          // Installing the tag on the last word makes the retry lookup hit.
          if (last_word) bus.arr_tag_we = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  ADDRESS_WIDTH, 32, CPU/memory word address width
  DATA_WIDTH, 32, word width
  TAG_WIDTH, 18, tag field = addr[31:14]
  SET_WIDTH, 8, set field = addr[13:6]
  OFFSET_WIDTH, 6, word-in-block field = addr[5:0]; block = 2**OFFSET_WIDTH words
  WAY, 4, associativity; way index width WW = log2(WAY)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  cpu_req  in  1  request; held by CPU until cpu_ready
  cpu_we  in  1  1=write, 0=read
  cpu_addr  in  ADDRESS_WIDTH  request address
  cpu_wdata  in  DATA_WIDTH  write data
  cpu_ready  out  1  one-cycle completion pulse
  cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ready
  busy  out  1  state != IDLE
  arr_hit  in  1  array tag match for arr_set/latched tag
  arr_hit_way  in  WW  matching way
  arr_victim_way  in  WW  LRU victim way of arr_set
  arr_victim_dirty  in  1  dirty bit of victim
  arr_victim_tag  in  TAG_WIDTH  tag of victim
  arr_rdata  in  DATA_WIDTH  word at arr_set/arr_way/arr_offset (combinational)
  arr_set  out  SET_WIDTH  addressed set
  arr_way  out  WW  addressed way
  arr_offset  out  OFFSET_WIDTH  addressed word
  arr_wdata  out  DATA_WIDTH  word write data
  arr_data_we  out  1  word write strobe
  arr_tag_we  out  1  write tag, valid=1, dirty=arr_dirty_val
  arr_dirty_val  out  1  dirty value for arr_tag_we
  arr_lru_touch  out  1  mark arr_way most-recently-used
  mem_req  out  1  memory word request
  mem_we  out  1  1=writeback word, 0=refill word
  mem_addr  out  ADDRESS_WIDTH  memory word address
  mem_wdata  out  DATA_WIDTH  writeback data
  mem_ack  in  1  memory accepts/returns word this cycle
  mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ack

Function
REQ-003 FSM states SHALL be IDLE, LOOKUP, WRITEBACK, REFILL; encoding free.
REQ-004 IDLE: cpu_req=1 and cpu_ready=0 -> latch addr/we/wdata, go LOOKUP; cpu_req sampled in the cpu_ready cycle SHALL be ignored.
REQ-005 arr_set and tag compare SHALL use latched address only; cpu_* changes after acceptance have no effect.
REQ-006 LOOKUP hit read: cpu_rdata<=arr_rdata, cpu_ready<=1 at next edge, arr_way=arr_hit_way, arr_lru_touch=1, go IDLE.
REQ-007 LOOKUP hit write: same cycle arr_data_we=1, arr_wdata=latched wdata, arr_tag_we=1, arr_dirty_val=1, arr_lru_touch=1; cpu_ready<=1, go IDLE.
REQ-008 LOOKUP miss: latch arr_victim_way and arr_victim_tag, counter cnt<=0; dirty victim -> WRITEBACK, else REFILL.
REQ-009 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim_tag,set,cnt}, arr_way=victim, arr_offset=cnt, mem_wdata=arr_rdata; each mem_ack -> cnt+1; ack at cnt=2**OFFSET_WIDTH-1 -> cnt<=0, REFILL.
REQ-010 REFILL: mem_req=1, mem_we=0, mem_addr={tag,set,cnt}; mem_ack -> same cycle arr_data_we=1, arr_way=victim, arr_offset=cnt, arr_wdata=mem_rdata, cnt+1; final ack also arr_tag_we=1, arr_dirty_val=0, go LOOKUP (retry hits).
REQ-011 mem_req/mem_we/mem_addr/mem_wdata SHALL stay stable until mem_ack; mem_ack outside WRITEBACK/REFILL ignored; mem_ack in first request cycle allowed.
REQ-012 All arr_*_we, arr_lru_touch, mem_req SHALL be 0 in IDLE; cpu_ready high exactly one cycle per request.
REQ-013 cnt SHALL be OFFSET_WIDTH bits, wrapping to 0 after final word.
REQ-014 Latency: hit = cpu_ready 2 cycles after accepting edge; clean miss = 2**OFFSET_WIDTH acks + 3 cycles minimum.

Reset
REQ-015 reset_n low SHALL immediately force IDLE, cnt=0, all latches 0, every output 0 (cpu_rdata=0, mem_req=0); reset mid-burst abandons burst without array writes.
REQ-016 First request accepted on first rising clk edge after reset_n deasserts.

Verification
REQ-017 Read hit: arr_hit=1, arr_rdata=0xDEADBEEF -> cpu_ready 2 cycles after accept, cpu_rdata=0xDEADBEEF, arr_lru_touch once.
REQ-018 Write hit addr 0x0000_4044, wdata 0x1234 -> arr_set=0x01, arr_offset=0x04, arr_data_we+arr_tag_we dirty=1 one cycle, cpu_ready.
REQ-019 Clean miss addr 0x0001_0080 -> 64 refill requests 0x0001_0080..0x0001_00BF, 64 arr_data_we, arr_tag_we dirty=0, retry hit, cpu_ready.
REQ-020 Dirty miss, victim_tag=0x3 set=0x02 -> 64 writes at 0x0000_C080..0x0000_C0BF before any refill request.
REQ-021 mem_ack stalled 5 cycles per word -> mem_addr/mem_req stable throughout; cpu_req toggled while busy ignored.
REQ-022 reset_n low during word 10 of refill -> outputs 0 same cycle, IDLE, no further arr_data_we.
